// File: rtl/sfq_dec_pkg.sv
// sfq_dec_pkg: window states, error-bit indices and helpers for the SFQ toggle decoder
package sfq_dec_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, OPEN} dec_state_t;
  localparam int ERR_STRAY   = 0;
  localparam int ERR_DOUBLE  = 1;
  localparam int ERR_OVERRUN = 2;
  localparam int N_ERR       = 3;
  function automatic logic [1:0] ones3(input logic [N_ERR-1:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction
endpackage

// File: rtl/sfq_toggle_decoder_fifo.sv
// sfq_bit_fifo: single-bit FIFO with synchronous active-low reset and full/empty flags
module sfq_bit_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem;
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  always_comb begin
    full    = cnt == (AW+1)'(DEPTH);
    empty   = cnt == '0;
    do_push = push & !full;
    do_pop  = pop & !empty;
    dout    = mem[rd] & !empty;
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      wr  <= wr + AW'(do_push);
      rd  <= rd + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/sfq_toggle_decoder.sv
// sfq_toggle_decoder: recovers one bit per SFQ clock pulse from toggle-coded lines, with timing-fault flags
module sfq_toggle_decoder
  import sfq_dec_pkg::*;
#(
  parameter int WIN_MIN    = 10,
  parameter int WIN_MAX    = 20,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sfq_clk_t,
  input  logic             sfq_q_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             err_stray,
  output logic             err_double,
  output logic             err_overrun,
  output logic             err_overflow,
  output logic [CNT_W-1:0] err_count,
  input  logic             clear_err
);
  localparam int CW = $clog2(WIN_MAX + 1);
  logic clk_prev, q_prev, primed, clk_pulse, q_pulse;
  dec_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic got, busy, open_w, data_ok, resolve, res_bit, push_req, push_bit, full, empty, drop;
  logic [N_ERR-1:0] err_now, err_q;
  logic [2:0] inc;
  logic [CNT_W:0] sum;
  always_ff @(posedge clk)
    if (!rst_n) begin
      clk_prev  <= 1'b0;
      q_prev    <= 1'b0;
      primed    <= 1'b0;
      clk_pulse <= 1'b0;
      q_pulse   <= 1'b0;
    end else begin
      clk_prev  <= sfq_clk_t;
      q_prev    <= sfq_q_t;
      primed    <= 1'b1;
      clk_pulse <= primed & (sfq_clk_t ^ clk_prev);
      q_pulse   <= primed & (sfq_q_t ^ q_prev);
    end
  // cnt holds the tick distance from the clock pulse for the cycle in which it is read
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      got   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= clk_pulse ? CW'(1) : (state_nx == IDLE ? '0 : cnt + 1'b1);
      got   <= !clk_pulse & (got | data_ok);
    end
  always_comb
    state_nx = clk_pulse ? WAIT
             : (state == WAIT && cnt == CW'(WIN_MIN - 1)) ? OPEN
             : (state == OPEN && cnt == CW'(WIN_MAX)) ? IDLE
             : state;
  // a data pulse coincident with a clock pulse is judged against the window being closed
  always_comb begin
    busy                 = state != IDLE;
    open_w               = state == OPEN;
    data_ok              = q_pulse & open_w & !got;
    resolve              = busy & (clk_pulse | cnt == CW'(WIN_MAX));
    res_bit              = got | data_ok;
    err_now              = '0;
    err_now[ERR_STRAY]   = q_pulse & !open_w;
    err_now[ERR_DOUBLE]  = q_pulse & open_w & got;
    err_now[ERR_OVERRUN] = clk_pulse & busy;
    drop                 = push_req & full;
    inc                  = 3'(ones3(err_now)) + 3'(drop);
    sum                  = {1'b0, err_count} + (CNT_W+1)'(inc);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      push_req     <= 1'b0;
      push_bit     <= 1'b0;
      err_q        <= '0;
      err_overflow <= 1'b0;
      err_count    <= '0;
    end else begin
      push_req     <= resolve;
      push_bit     <= res_bit;
      err_q        <= err_now;
      err_overflow <= !clear_err & (err_overflow | drop);
      err_count    <= clear_err ? '0 : (sum[CNT_W] ? '1 : sum[CNT_W-1:0]);
    end
  assign err_stray   = err_q[ERR_STRAY];
  assign err_double  = err_q[ERR_DOUBLE];
  assign err_overrun = err_q[ERR_OVERRUN];
  assign out_valid   = !empty;
  sfq_bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (push_bit),
    .pop   (out_valid & out_ready),
    .dout  (out_bit),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_sfq_toggle_decoder.sv
// tb_sfq_toggle_decoder: event-level reference model of the toggle decoder checked against randomized and directed pulse trains
module tb_sfq_toggle_decoder;
  localparam int WIN_MIN = 10;
  localparam int WIN_MAX = 20;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 16;
  logic clk = 1'b0, rst_n = 1'b0, sfq_clk_t = 1'b0, sfq_q_t = 1'b0, out_ready = 1'b1, clear_err = 1'b0;
  logic out_valid, out_bit, err_stray, err_double, err_overrun, err_overflow;
  logic [CNT_W-1:0] err_count;
  int n_vec = 0, n_bad = 0;
  int cq[$], qq[$];
  bit got_bits[$], exp_bits[$];
  int s_stray, s_double, s_overrun, e_stray, e_double, e_overrun, first_valid;
  always #5 clk = ~clk;
  sfq_toggle_decoder #(.WIN_MIN(WIN_MIN), .WIN_MAX(WIN_MAX), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sfq_clk_t    (sfq_clk_t),
    .sfq_q_t      (sfq_q_t),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bit      (out_bit),
    .err_stray    (err_stray),
    .err_double   (err_double),
    .err_overrun  (err_overrun),
    .err_overflow (err_overflow),
    .err_count    (err_count),
    .clear_err    (clear_err)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // each data pulse belongs to the latest clock pulse strictly before it; distance decides legality
  task automatic model();
    bit w[$];
    int o;
    e_stray = 0;
    e_double = 0;
    e_overrun = 0;
    exp_bits.delete();
    foreach (cq[i]) w.push_back(1'b0);
    foreach (qq[j]) begin
      o = -1;
      foreach (cq[i]) if (cq[i] < qq[j]) o = i;
      if (o < 0 || qq[j] - cq[o] < WIN_MIN || qq[j] - cq[o] > WIN_MAX) e_stray++;
      else if (w[o]) e_double++;
      else w[o] = 1'b1;
    end
    foreach (cq[i]) begin
      exp_bits.push_back(w[i]);
      if (i + 1 < cq.size() && cq[i+1] - cq[i] <= WIN_MAX) e_overrun++;
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_flags", int'({out_valid, out_bit, err_stray, err_double, err_overrun, err_overflow}), 0);
    chk("reset_count", int'(err_count), 0);
    rst_n = 1'b1;
  endtask
  task automatic run();
    int len, ci, qi;
    len = cq.size() ? cq[$] : 0;
    if (qq.size() && qq[$] > len) len = qq[$];
    len += 40;
    do_reset();
    model();
    got_bits.delete();
    s_stray = 0;
    s_double = 0;
    s_overrun = 0;
    first_valid = -1;
    ci = 0;
    qi = 0;
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      if (out_valid && out_ready) got_bits.push_back(out_bit);
      if (out_valid && first_valid < 0) first_valid = t;
      s_stray   += int'(err_stray);
      s_double  += int'(err_double);
      s_overrun += int'(err_overrun);
      if (ci < cq.size() && cq[ci] == t) begin sfq_clk_t = ~sfq_clk_t; ci++; end
      if (qi < qq.size() && qq[qi] == t) begin sfq_q_t = ~sfq_q_t; qi++; end
    end
  endtask
  task automatic compare(input string nm);
    chk({nm, "_nbits"}, got_bits.size(), exp_bits.size());
    foreach (exp_bits[i]) if (i < got_bits.size()) chk($sformatf("%s_bit%0d", nm, i), int'(got_bits[i]), int'(exp_bits[i]));
    chk({nm, "_stray"}, s_stray, e_stray);
    chk({nm, "_double"}, s_double, e_double);
    chk({nm, "_overrun"}, s_overrun, e_overrun);
    chk({nm, "_count"}, int'(err_count), e_stray + e_double + e_overrun);
    chk({nm, "_overflow"}, int'(err_overflow), 0);
  endtask
  initial begin
    int c, d;
    cq = '{5, 35, 65}; qq = '{18, 48, 78}; run(); compare("t1_ones");
    cq = '{5, 35, 65}; qq = '{}; run(); compare("t2_zeros");
    chk("t2_latency", first_valid, 5 + 23);
    cq = '{5}; qq = '{10}; run(); compare("t3_early");
    cq = '{5}; qq = '{17, 20}; run(); compare("t4_double");
    cq = '{5, 13}; qq = '{}; run(); compare("t5_overrun");
    cq = '{5, 40}; qq = '{14, 15, 25, 50, 61}; run(); compare("t7_edges");
    cq = '{5, 25, 46}; qq = '{25}; run(); compare("t8_coincide");
    for (int k = 0; k < 8; k++) begin
      cq.delete();
      qq.delete();
      c = 5;
      repeat ($urandom_range(4, 10)) begin
        cq.push_back(c);
        c += $urandom_range(5, 35);
      end
      d = $urandom_range(5, 15);
      while (d < cq[$] + 30) begin
        qq.push_back(d);
        d += $urandom_range(2, 20);
      end
      run();
      compare($sformatf("rnd%0d", k));
    end
    cq.delete();
    qq.delete();
    for (int i = 0; i < 9; i++) begin
      cq.push_back(5 + 30 * i);
      if (i % 2 == 0) qq.push_back(5 + 30 * i + 13);
    end
    out_ready = 1'b0;
    run();
    chk("t6_valid", int'(out_valid), 1);
    chk("t6_overflow", int'(err_overflow), 1);
    chk("t6_count", int'(err_count), 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("t6_clr_overflow", int'(err_overflow), 0);
    chk("t6_clr_count", int'(err_count), 0);
    out_ready = 1'b1;
    got_bits.delete();
    repeat (12) begin
      if (out_valid) got_bits.push_back(out_bit);
      @(negedge clk);
    end
    chk("t6_held", got_bits.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) if (i < got_bits.size()) chk($sformatf("t6_bit%0d", i), int'(got_bits[i]), int'(exp_bits[i]));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
